dot_product_seq: RTL and testbench
==================================

Name: dot_product_seq

Overview:
Operand sequencer on the driving side of mac_Nbits. It holds a small local buffer of weight/input pairs. On start it clears the MAC, streams len pairs into it with enable, and captures the final accumulator as a dot-product result with a done pulse. It sits between the host/control logic and the MAC datapath and owns all MAC control (clear, enable, operands).

Parameters:
WIDTH, 8, operand width (signed); MAC result is 2*WIDTH
DEPTH, 16, number of (w, x) pairs in the local buffer
ADDR_W, 4, buffer address width; DEPTH equals 2**ADDR_W

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  buffer write strobe
wr_addr  in  ADDR_W  buffer write address
wr_w  in  WIDTH  signed weight to store
wr_x  in  WIDTH  signed input to store
start  in  1  start request, sampled in IDLE only
len  in  ADDR_W+1  number of pairs to accumulate, sampled with start
busy  out  1  high from the cycle after start is accepted until the cycle done rises
done  out  1  one-cycle pulse; result valid in the same cycle
result  out  2*WIDTH  signed dot product, held until the next done
mac_clr  out  1  active-high synchronous clear to the MAC
mac_en  out  1  MAC enable
mac_w  out  WIDTH  weight operand to the MAC
mac_x  out  WIDTH  input operand to the MAC
mac_out  in  2*WIDTH  MAC accumulator (registered: out <= out + w*x when enabled)
chk_err  out  1  sticky self-check mismatch flag (see Optional Feature)

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; busy, done, mac_clr, mac_en, chk_err = 0; result = 0; idx = 0; all buffer entries = 0. Reset mid-run aborts with no done.
- Buffer writes: wr_en=1 in IDLE writes wbuf[wr_addr]=wr_w and xbuf[wr_addr]=wr_x at the edge. Writes while busy are ignored.
- FSM states are IDLE, CLEAR, RUN, CAPTURE.
- IDLE: if start=1, latch n = min(len, DEPTH), go to CLEAR.
- CLEAR: mac_clr=1 for exactly one cycle, idx=0. If n=0, go to CAPTURE; otherwise go to RUN.
- RUN: mac_en=1, mac_w=wbuf[idx], mac_x=xbuf[idx], driven from registered state and idx. The MAC samples one pair per edge. idx increments; after the edge with idx=n-1, go to CAPTURE.
- CAPTURE: mac_en=0 and mac_out is final. At the edge, result<=mac_out, done<=1, go to IDLE.
- Outside RUN, mac_en=0 and mac_w=mac_x=0.
- Latency: if start is sampled at edge k, done is high in the cycle after edge k+n+2 (n+3 cycles after the start cycle).
- start during busy is ignored. start in the done cycle is accepted, giving back-to-back runs.
- Arithmetic is performed entirely by the MAC. result is the 2*WIDTH two's-complement value of mac_out and wraps exactly as the MAC does.

Optional Feature:
Macro DOTSEQ_SELF_CHECK_EN.
- Defined: an internal shadow accumulator of width 2*WIDTH clears in CLEAR and adds the sign-extended product of mac_w*mac_x each RUN cycle. In CAPTURE, if shadow != mac_out, chk_err is set; it stays set until reset.
- Undefined: no shadow logic; chk_err is tied to 0.

Decomposition:
- Shared package holds the state encoding constants (IDLE=2'd0, CLEAR=2'd1, RUN=2'd2, CAPTURE=2'd3) and the default WIDTH/DEPTH localparams, so mac_Nbits and this block agree.
- One natural sub-module is dot_pair_buf: the dual register file with one write port and one combinational read port.

Test Plan:
- Load (w,x) = (-3,2),(5,-4); start with len=2 -> mac_en high 2 cycles, done after 5 cycles, result=-26, busy low with done.
- len=0 -> one mac_clr pulse, no mac_en, done 3 cycles after start, result=0.
- Load entries 0..15 with w=-128, x=-128; len=16 -> result=262144 wrapped to 16 bits, i.e. 0; DEPTH boundary hit; len=20 behaves identically to len=16.
- Assert start and perform writes during RUN -> both ignored; result of the first run unchanged; the buffer is unchanged on a later run.
- Drop rst_n mid-RUN -> busy, mac_en, done, result go to 0 immediately; the next run with (6,-8), len=1 gives -48.
- With DOTSEQ_SELF_CHECK_EN defined, force mac_out off by 1 -> chk_err=1 after CAPTURE and stays 1; without the macro, chk_err stays 0.

Source files
------------

// File: rtl/dot_product_seq_pkg.sv
// Shared definitions for the dot-product sequencer and its MAC datapath:
// state encoding and default operand/buffer sizes.
package dot_product_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_RUN     = 2'd2,
        ST_CAPTURE = 2'd3
    } dotseq_state_e;

    localparam int DOTSEQ_WIDTH  = 8;
    localparam int DOTSEQ_DEPTH  = 16;
    localparam int DOTSEQ_ADDR_W = 4;

endpackage

// File: rtl/dot_product_seq_buf.sv
// Dual (weight, input) register file: one synchronous write port and one
// combinational read port sharing a single address.
module dot_pair_buf #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_w_i,
    input  logic [WIDTH-1:0]  wr_x_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_w_o,
    output logic [WIDTH-1:0]  rd_x_o
);

    logic [WIDTH-1:0] wbuf_q [DEPTH];
    logic [WIDTH-1:0] xbuf_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                wbuf_q[i] <= '0;
                xbuf_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            wbuf_q[wr_addr_i] <= wr_w_i;
            xbuf_q[wr_addr_i] <= wr_x_i;
        end
    end

    assign rd_w_o = wbuf_q[rd_addr_i];
    assign rd_x_o = xbuf_q[rd_addr_i];

endmodule

// File: rtl/dot_product_seq.sv
// Operand sequencer driving an external MAC; optional shadow accumulator
// cross-check enabled by defining DOTSEQ_SELF_CHECK_EN.
//
// state   | meaning
// IDLE    | waiting for start, buffer writable
// CLEAR   | one-cycle MAC clear, idx reset
// RUN     | stream pair idx into the MAC, one per cycle
// CAPTURE | MAC settled; latch result and pulse done
module dot_product_seq
    import dot_product_seq_pkg::*;
#(
    parameter int WIDTH  = DOTSEQ_WIDTH,
    parameter int DEPTH  = DOTSEQ_DEPTH,
    parameter int ADDR_W = DOTSEQ_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [WIDTH-1:0]     wr_w,
    input  logic [WIDTH-1:0]     wr_x,
    input  logic                 start,
    input  logic [ADDR_W:0]      len,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 mac_clr,
    output logic                 mac_en,
    output logic [WIDTH-1:0]     mac_w,
    output logic [WIDTH-1:0]     mac_x,
    input  logic [2*WIDTH-1:0]   mac_out,
    output logic                 chk_err
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

    dotseq_state_e       state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W:0]     n_q, n_d;
    logic [2*WIDTH-1:0]  result_q, result_d;
    logic                done_q, done_d;
    logic [WIDTH-1:0]    rd_w, rd_x;

    dot_pair_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en && (state_q == ST_IDLE)),
        .wr_addr_i (wr_addr),
        .wr_w_i    (wr_w),
        .wr_x_i    (wr_x),
        .rd_addr_i (idx_q),
        .rd_w_o    (rd_w),
        .rd_x_o    (rd_x)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            n_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            n_q      <= n_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        n_d      = n_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_d     = (len > DEPTH_L) ? DEPTH_L : len;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                idx_d   = '0;
                state_d = (n_q == '0) ? ST_CAPTURE : ST_RUN;
            end
            ST_RUN: begin
                idx_d = idx_q + ADDR_W'(1);
                if ({1'b0, idx_q} == (n_q - LEN_ONE)) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                result_d = mac_out;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign result  = result_q;
    assign mac_clr = (state_q == ST_CLEAR);
    assign mac_en  = (state_q == ST_RUN);
    assign mac_w   = mac_en ? rd_w : '0;
    assign mac_x   = mac_en ? rd_x : '0;

`ifdef DOTSEQ_SELF_CHECK_EN
    logic [2*WIDTH-1:0] shadow_q;
    logic               chk_err_q;
    logic [2*WIDTH-1:0] prod;

    // Sign-extend before multiplying so the low 2*WIDTH bits wrap like the MAC.
    assign prod = {{WIDTH{mac_w[WIDTH-1]}}, mac_w} * {{WIDTH{mac_x[WIDTH-1]}}, mac_x};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= '0;
            chk_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR:   shadow_q <= '0;
                ST_RUN:     shadow_q <= shadow_q + prod;
                ST_CAPTURE: if (shadow_q != mac_out) chk_err_q <= 1'b1;
                default:    ;
            endcase
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_dot_product_seq.sv
// Directed bench for dot_product_seq with a behavioural MAC model on mac_out.
module tb_dot_product_seq;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_w;
    logic [7:0]  wr_x;
    logic        start;
    logic [4:0]  len;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        mac_clr;
    logic        mac_en;
    logic [7:0]  mac_w;
    logic [7:0]  mac_x;
    logic [15:0] mac_out;
    logic        chk_err;

    logic [15:0] mac_acc;
    logic [15:0] mac_prod;
    logic [15:0] mac_bias;
    logic        exp_chk;
    int          checks;
    int          errors;

    dot_product_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_w    (wr_w),
        .wr_x    (wr_x),
        .start   (start),
        .len     (len),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .mac_clr (mac_clr),
        .mac_en  (mac_en),
        .mac_w   (mac_w),
        .mac_x   (mac_x),
        .mac_out (mac_out),
        .chk_err (chk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External MAC model: registered accumulate, synchronous clear, optional bias fault.
    assign mac_prod = {{8{mac_w[7]}}, mac_w} * {{8{mac_x[7]}}, mac_x};
    assign mac_out  = mac_acc + mac_bias;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      mac_acc <= 16'd0;
        else if (mac_clr) mac_acc <= 16'd0;
        else if (mac_en)  mac_acc <= mac_acc + mac_prod;
    end

    task automatic wr(input logic [3:0] a, input logic [7:0] w, input logic [7:0] x);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_w = w; wr_x = x;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic run_dot(input logic [4:0] len_v, input logic [15:0] exp_res,
                           input int n_exp, input string name, input bit inject);
        int cyc, en_cnt, clr_cnt, busy_bad, op_bad;
        bit got;
        cyc = 0; en_cnt = 0; clr_cnt = 0; busy_bad = 0; op_bad = 0; got = 0;
        @(negedge clk);
        start = 1'b1; len = len_v;
        while (!got && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (inject && cyc == 2) begin
                start = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_w = 8'd100; wr_x = 8'd100;
            end
            if (inject && cyc == 4) begin
                start = 1'b0; wr_en = 1'b0;
            end
            if (mac_en) en_cnt++;
            if (mac_clr) clr_cnt++;
            if (!mac_en && (mac_w !== 8'd0 || mac_x !== 8'd0)) op_bad++;
            if (done) got = 1;
            else if (!busy) busy_bad++;
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL %s done_timeout: no done within %0d cycles", name, cyc);
        end
        checks++;
        if (cyc !== n_exp + 3) begin
            errors++; $display("FAIL %s latency: got %0d cycles want %0d", name, cyc, n_exp + 3);
        end
        checks++;
        if (result !== exp_res) begin
            errors++; $display("FAIL %s result: got %0d want %0d", name, $signed(result), $signed(exp_res));
        end
        checks++;
        if (en_cnt !== n_exp) begin
            errors++; $display("FAIL %s mac_en_cycles: got %0d want %0d", name, en_cnt, n_exp);
        end
        checks++;
        if (clr_cnt !== 1) begin
            errors++; $display("FAIL %s mac_clr_pulses: got %0d want 1", name, clr_cnt);
        end
        checks++;
        if (busy !== 1'b0 || busy_bad !== 0) begin
            errors++; $display("FAIL %s busy: done-cycle busy %b, low-while-running %0d, want 0/0", name, busy, busy_bad);
        end
        checks++;
        if (op_bad !== 0) begin
            errors++; $display("FAIL %s idle_operands: %0d nonzero cycles want 0", name, op_bad);
        end
        checks++;
        if (chk_err !== exp_chk) begin
            errors++; $display("FAIL %s chk_err: got %b want %b", name, chk_err, exp_chk);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== exp_res) begin
            errors++; $display("FAIL %s after_done: done %b busy %b result %0d want 0 0 %0d",
                               name, done, busy, $signed(result), $signed(exp_res));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, mac_clr, mac_en, chk_err} !== 5'b0 || result !== 16'd0 ||
            mac_w !== 8'd0 || mac_x !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: busy %b done %b clr %b en %b chk %b result %h w %h x %h want all 0",
                     busy, done, mac_clr, mac_en, chk_err, result, mac_w, mac_x);
        end
        rst_n = 1'b1;
        run_dot(5'd16, 16'd0, 16, "reset_buffer_zero", 1'b0);
    endtask

    task automatic test_basic();
        wr(4'd0, -8'sd3, 8'sd2);
        wr(4'd1, 8'sd5, -8'sd4);
        run_dot(5'd2, -16'sd26, 2, "basic_len2", 1'b0);
        run_dot(5'd1, -16'sd6, 1, "basic_len1", 1'b0);
    endtask

    task automatic test_len_zero();
        run_dot(5'd0, 16'd0, 0, "len_zero", 1'b0);
    endtask

    task automatic test_depth();
        for (int i = 0; i < 16; i++) wr(4'(i), -8'sd128, -8'sd128);
        run_dot(5'd16, 16'd0, 16, "depth_len16", 1'b0);
        run_dot(5'd20, 16'd0, 16, "depth_len20_sat", 1'b0);
        run_dot(5'd15, 16'hC000, 15, "depth_len15", 1'b0);
        run_dot(5'd3, 16'hC000, 3, "depth_len3", 1'b0);
    endtask

    task automatic test_busy_ignore();
        wr(4'd0, -8'sd3, 8'sd2);
        wr(4'd1, 8'sd5, -8'sd4);
        run_dot(5'd2, -16'sd26, 2, "busy_inject", 1'b1);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL busy_start_ignored: busy %b done %b want 0 0", busy, done);
        end
        run_dot(5'd2, -16'sd26, 2, "busy_buffer_unchanged", 1'b0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; len = 5'd16;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (mac_en !== 1'b1) begin
            errors++; $display("FAIL abort_in_run: mac_en %b want 1", mac_en);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || mac_en !== 1'b0 || done !== 1'b0 || result !== 16'd0 || mac_clr !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: busy %b en %b done %b clr %b result %0d want all 0",
                     busy, mac_en, done, mac_clr, $signed(result));
        end
        @(negedge clk);
        rst_n = 1'b1;
        wr(4'd0, 8'sd6, -8'sd8);
        run_dot(5'd1, -16'sd48, 1, "after_abort_len1", 1'b0);
        run_dot(5'd16, -16'sd48, 16, "after_abort_buf_cleared", 1'b0);
    endtask

    task automatic test_self_check();
        mac_bias = 16'd1;
`ifdef DOTSEQ_SELF_CHECK_EN
        exp_chk = 1'b1;
`else
        exp_chk = 1'b0;
`endif
        run_dot(5'd1, -16'sd47, 1, "chk_fault", 1'b0);
        mac_bias = 16'd0;
        run_dot(5'd1, -16'sd48, 1, "chk_sticky", 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (chk_err !== 1'b0) begin
            errors++; $display("FAIL chk_reset: got %b want 0", chk_err);
        end
        exp_chk = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = 4'd0; wr_w = 8'd0; wr_x = 8'd0;
        start = 1'b0; len = 5'd0; mac_bias = 16'd0; exp_chk = 1'b0;
        test_reset();
        test_basic();
        test_len_zero();
        test_depth();
        test_busy_ignore();
        test_reset_mid();
        test_self_check();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
